// File: rtl/crc_chk_pkg.sv
// crc_chk_pkg: shared state encoding and the serial CRC step used by the checker and the generator.
package crc_chk_pkg;

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    localparam int CRC_MAX_W = 32;

    // Left-shifting LFSR step for any width n <= CRC_MAX_W; the result is masked to n bits.
    function automatic logic [CRC_MAX_W-1:0] crc_step(
        input logic [CRC_MAX_W-1:0] rem,
        input logic                 b,
        input logic [CRC_MAX_W-1:0] poly,
        input int                   n
    );
        logic [CRC_MAX_W-1:0] mask;
        logic                 msb;
        mask = (n >= CRC_MAX_W) ? '1 : (CRC_MAX_W'(1) << n) - CRC_MAX_W'(1);
        msb  = |(rem & (CRC_MAX_W'(1) << (n - 1)));
        return ({rem[CRC_MAX_W-2:0], b} ^ (msb ? poly : '0)) & mask;
    endfunction

endpackage

// File: rtl/crc_stream_checker_lfsr.sv
// crc_lfsr_core: remainder register with seed load and enable-gated serial step.
module crc_lfsr_core
    import crc_chk_pkg::*;
#(
    parameter int                N_POLY = 8,
    parameter logic [N_POLY-1:0] POLY   = 'h07
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              load,
    input  logic              step,
    input  logic              bit_in,
    input  logic [N_POLY-1:0] seed,
    output logic [N_POLY-1:0] rem_next
);

    logic [N_POLY-1:0] rem;
    logic [N_POLY-1:0] base;

    // A bit coincident with load is stepped into the seed, not the old remainder.
    always_comb begin
        base     = load ? seed : rem;
        rem_next = step ? N_POLY'(crc_step(CRC_MAX_W'(base), bit_in, CRC_MAX_W'(POLY), N_POLY)) : base;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) rem <= '0;
        else       rem <= rem_next;
    end

endmodule

// File: rtl/crc_stream_checker.sv
// crc_stream_checker: serial CRC checker for framed bit streams with held, acknowledged results.
// Defining CRC_CHECK_STATS_EN adds saturating good/bad frame counters.
module crc_stream_checker
    import crc_chk_pkg::*;
#(
    parameter int                N_POLY  = 8,
    parameter logic [N_POLY-1:0] POLY    = 'h07,
    parameter logic [N_POLY-1:0] RESIDUE = '0,
    parameter int                CNT_W   = 16
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [N_POLY-1:0] SEED,
    input  logic              FRAME_START,
    input  logic              BIT_VALID,
    input  logic              NEXT_BIT,
    input  logic              FRAME_END,
    input  logic              RESULT_ACK,
    output logic              BUSY,
    output logic              RESULT_VALID,
    output logic              CRC_OK,
    output logic              ERR_SHORT,
    output logic [CNT_W-1:0]  BIT_COUNT,
    output logic [N_POLY-1:0] REMAINDER,
    output logic [15:0]       FRAMES_OK,
    output logic [15:0]       FRAMES_BAD
);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [N_POLY-1:0] rem_next;
    logic              step, fin, short_next, ok_next;

    crc_lfsr_core #(.N_POLY(N_POLY), .POLY(POLY)) u_core (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .load     (FRAME_START),
        .step     (step),
        .bit_in   (NEXT_BIT),
        .seed     (SEED),
        .rem_next (rem_next)
    );

    // FRAME_START wins in every state: it starts, restarts or implicitly acks.
    always_comb begin
        step       = BIT_VALID && (FRAME_START || state == RECV);
        fin        = state == RECV && !FRAME_START && FRAME_END;
        cnt_next   = FRAME_START ? CNT_W'(BIT_VALID)
                   : (state == RECV && BIT_VALID && cnt != '1) ? cnt + CNT_W'(1) : cnt;
        short_next = cnt_next < CNT_W'(N_POLY + 1);
        ok_next    = rem_next == RESIDUE && !short_next && cnt_next != '1;
        state_next = FRAME_START ? RECV
                   : fin ? DONE
                   : (state == DONE && RESULT_ACK) ? IDLE : state;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            BUSY         <= 1'b0;
            RESULT_VALID <= 1'b0;
            CRC_OK       <= 1'b0;
            ERR_SHORT    <= 1'b0;
            BIT_COUNT    <= '0;
            REMAINDER    <= '0;
        end else begin
            BUSY         <= state_next == RECV;
            RESULT_VALID <= state_next == DONE;
            if (fin) begin
                CRC_OK    <= ok_next;
                ERR_SHORT <= short_next;
                BIT_COUNT <= cnt_next;
                REMAINDER <= rem_next;
            end
        end
    end

`ifdef CRC_CHECK_STATS_EN
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            FRAMES_OK  <= '0;
            FRAMES_BAD <= '0;
        end else if (fin) begin
            if (ok_next && FRAMES_OK != '1)        FRAMES_OK  <= FRAMES_OK + 16'd1;
            else if (!ok_next && FRAMES_BAD != '1) FRAMES_BAD <= FRAMES_BAD + 16'd1;
        end
    end
`else
    assign FRAMES_OK  = '0;
    assign FRAMES_BAD = '0;
`endif

endmodule

// File: tb/tb_crc_stream_checker.sv
// tb_crc_stream_checker: table of frames driven into the checker; results scoreboarded on RESULT_VALID.
module tb_crc_stream_checker;

    logic        CLOCK = 1'b0;
    logic        RESET, FRAME_START, BIT_VALID, NEXT_BIT, FRAME_END, RESULT_ACK;
    logic [7:0]  SEED;
    logic        BUSY, RESULT_VALID, CRC_OK, ERR_SHORT;
    logic [15:0] BIT_COUNT;
    logic [7:0]  REMAINDER;
    logic [15:0] FRAMES_OK, FRAMES_BAD;

    crc_stream_checker dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .SEED         (SEED),
        .FRAME_START  (FRAME_START),
        .BIT_VALID    (BIT_VALID),
        .NEXT_BIT     (NEXT_BIT),
        .FRAME_END    (FRAME_END),
        .RESULT_ACK   (RESULT_ACK),
        .BUSY         (BUSY),
        .RESULT_VALID (RESULT_VALID),
        .CRC_OK       (CRC_OK),
        .ERR_SHORT    (ERR_SHORT),
        .BIT_COUNT    (BIT_COUNT),
        .REMAINDER    (REMAINDER),
        .FRAMES_OK    (FRAMES_OK),
        .FRAMES_BAD   (FRAMES_BAD)
    );

    always #5 CLOCK = ~CLOCK;

    int cyc = 0;
    always @(posedge CLOCK) cyc++;

    typedef struct {
        int   nbits;
        int   flip;
        bit   coinc_start;
        bit   coinc_end;
        bit   gap;
        bit   ack;
        bit   exp_ok;
        bit   exp_short;
        int   exp_cnt;
    } vec_t;

    typedef struct {
        int         due;
        logic       ok;
        logic       short_f;
        logic [15:0] cnt;
        logic [7:0] rem;
    } exp_t;

    exp_t       sb[$];
    vec_t       vecs[9];
    int         n_vec = 0, n_bad = 0;
    int         exp_ok_n = 0, exp_bad_n = 0;
    logic       rv_q = 1'b0;
    logic [7:0] msg [0:9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    function automatic logic frame_bit(input int i, input int flip);
        logic [7:0] by;
        by = msg[i / 8] << (i % 8);
        return by[7] ^ (i == flip);
    endfunction

    function automatic logic [7:0] model_rem(input int n, input int flip);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r = {r[6:0], frame_bit(i, flip)} ^ (r[7] ? 8'h07 : 8'h00);
        return r;
    endfunction

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic idle_inputs();
        FRAME_START = 0; BIT_VALID = 0; NEXT_BIT = 0; FRAME_END = 0; RESULT_ACK = 0;
    endtask

    task automatic push(input vec_t v);
        sb.push_back('{cyc + 1, v.exp_ok, v.exp_short, 16'(v.exp_cnt), model_rem(v.nbits, v.flip)});
    endtask

    task automatic run_frame(input vec_t v);
        if (!v.coinc_start) begin
            FRAME_START = 1;
            tick();
            FRAME_START = 0;
            check("start_busy", BUSY, 1);
        end
        for (int i = 0; i < v.nbits; i++) begin
            FRAME_START = v.coinc_start && i == 0;
            BIT_VALID   = 1;
            NEXT_BIT    = frame_bit(i, v.flip);
            FRAME_END   = v.coinc_end && i == v.nbits - 1;
            if (FRAME_END) push(v);
            tick();
            if (FRAME_START) begin
                check("start_busy", BUSY, 1);
                check("start_drops_valid", RESULT_VALID, 0);
            end
            idle_inputs();
            if (v.gap && i == 10) tick();
        end
        if (!v.coinc_end) begin
            FRAME_END = 1;
            push(v);
            tick();
            FRAME_END = 0;
        end
        if (v.ack) begin
            BIT_VALID = 1; NEXT_BIT = 1; FRAME_END = 1;
            tick();
            idle_inputs();
            tick();
            check("hold_valid", RESULT_VALID, 1);
            check("hold_count", BIT_COUNT, v.exp_cnt);
            RESULT_ACK = 1;
            tick();
            RESULT_ACK = 0;
            check("ack_clears", RESULT_VALID, 0);
        end
    endtask

    always @(negedge CLOCK) begin
        exp_t e;
        if (RESULT_VALID && !rv_q) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = sb.pop_front();
                check("latency", 32'(cyc), 32'(e.due));
                check("crc_ok", CRC_OK, e.ok);
                check("err_short", ERR_SHORT, e.short_f);
                check("bit_count", BIT_COUNT, e.cnt);
                check("remainder", REMAINDER, e.rem);
                if (e.ok) exp_ok_n++; else exp_bad_n++;
`ifdef CRC_CHECK_STATS_EN
                check("frames_ok", FRAMES_OK, exp_ok_n);
                check("frames_bad", FRAMES_BAD, exp_bad_n);
`else
                check("frames_ok_tied", FRAMES_OK, 0);
                check("frames_bad_tied", FRAMES_BAD, 0);
`endif
            end
        end
        rv_q = RESULT_VALID;
    end

    initial begin
        vecs[0] = '{80, -1, 1, 1, 0, 1, 1, 0, 80};
        vecs[1] = '{80, -1, 1, 1, 0, 0, 1, 0, 80};
        vecs[2] = '{80, -1, 1, 1, 1, 1, 1, 0, 80};
        vecs[3] = '{80, -1, 0, 0, 1, 1, 1, 0, 80};
        vecs[4] = '{ 9, -1, 1, 0, 0, 1, 0, 0,  9};
        vecs[5] = '{ 8, -1, 0, 1, 0, 1, 0, 1,  8};
        vecs[6] = '{ 0, -1, 0, 0, 0, 1, 0, 1,  0};
        vecs[7] = '{80,  5, 1, 1, 0, 1, 0, 0, 80};
        vecs[8] = '{ 5, -1, 1, 1, 0, 1, 0, 1,  5};

        RESET = 1; SEED = '0;
        idle_inputs();
        tick();
        tick();
        check("reset_busy", BUSY, 0);
        check("reset_valid", RESULT_VALID, 0);
        check("reset_ok", CRC_OK, 0);
        check("reset_count", BIT_COUNT, 0);
        check("reset_rem", REMAINDER, 0);
        RESET = 0;
        tick();

        BIT_VALID = 1; NEXT_BIT = 1; FRAME_END = 1;
        tick();
        idle_inputs();
        tick();
        check("idle_ignore_valid", RESULT_VALID, 0);
        check("idle_ignore_busy", BUSY, 0);

        for (int k = 0; k < 9; k++) run_frame(vecs[k]);

        // Asynchronous reset in the middle of a frame, between clock edges.
        for (int i = 0; i < 20; i++) begin
            FRAME_START = i == 0; BIT_VALID = 1; NEXT_BIT = frame_bit(i, -1);
            tick();
        end
        idle_inputs();
        #2 RESET = 1;
        #1;
        check("async_busy", BUSY, 0);
        check("async_ok", CRC_OK, 0);
        check("async_short", ERR_SHORT, 0);
        check("async_count", BIT_COUNT, 0);
        check("async_rem", REMAINDER, 0);
        check("async_frames_ok", FRAMES_OK, 0);
        check("async_frames_bad", FRAMES_BAD, 0);
        exp_ok_n = 0; exp_bad_n = 0;
        #1 RESET = 0;
        tick();
        FRAME_END = 1;
        tick();
        FRAME_END = 0;
        tick();
        check("post_reset_no_result", RESULT_VALID, 0);

        // Abort after 30 bits, then a full good frame: only one result expected.
        for (int i = 0; i < 30; i++) begin
            FRAME_START = i == 0; BIT_VALID = 1; NEXT_BIT = frame_bit(i, -1);
            tick();
        end
        idle_inputs();
        run_frame(vecs[0]);

        tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
